// File: rtl/spi_pixel_if.sv
// Byte-in / pixel-out bundle of the SPI pixel assembler.
// The master side drives the receive bytes and CS. The slave side (the assembler) drives the pixel stream.
interface spi_pixel_if #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
);
    localparam int HW = $clog2(H_RES);
    localparam int VW = $clog2(V_RES);
    localparam int AW = $clog2(H_RES * V_RES);

    logic [7:0]    byte_in;
    logic          byte_valid_in;
    logic          chip_sel_in;
    logic [15:0]   pixel_out;
    logic          pixel_valid_out;
    logic [HW-1:0] hcount_out;
    logic [VW-1:0] vcount_out;
    logic [AW-1:0] addr_out;
    logic          frame_done_out;
    logic          frame_error_out;

    modport master (
        output byte_in,
        output byte_valid_in,
        output chip_sel_in,
        input  pixel_out,
        input  pixel_valid_out,
        input  hcount_out,
        input  vcount_out,
        input  addr_out,
        input  frame_done_out,
        input  frame_error_out
    );

    modport slave (
        input  byte_in,
        input  byte_valid_in,
        input  chip_sel_in,
        output pixel_out,
        output pixel_valid_out,
        output hcount_out,
        output vcount_out,
        output addr_out,
        output frame_done_out,
        output frame_error_out
    );
endinterface

// File: rtl/spi_pixel_assembler.sv
// Pairs quad-SPI receive bytes into RGB565 pixels and tags each pixel with its raster position.
// It also produces the linear frame-buffer address and flags short or overlong frames.
module spi_pixel_assembler #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    spi_pixel_if.slave     bus
);
    localparam int HW = $clog2(H_RES);
    localparam int VW = $clog2(V_RES);
    localparam int AW = $clog2(H_RES * V_RES);

    localparam logic [HW-1:0] H_LAST = HW'(H_RES - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    high_reg, high_next;

    // Position of the next pixel to be emitted
    logic [HW-1:0] hcount_reg, hcount_next;
    logic [VW-1:0] vcount_reg, vcount_next;
    logic [AW-1:0] addr_reg, addr_next;

    // Registered outputs
    logic [15:0]   pixel_reg, pixel_next;
    logic [HW-1:0] hcount_out_reg, hcount_out_next;
    logic [VW-1:0] vcount_out_reg, vcount_out_next;
    logic [AW-1:0] addr_out_reg, addr_out_next;
    logic          pixel_valid_reg, pixel_valid_next;
    logic          frame_done_reg, frame_done_next;
    logic          frame_error_reg, frame_error_next;

    logic          last_pixel;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_reg       <= IDLE;
            high_reg        <= '0;
            hcount_reg      <= '0;
            vcount_reg      <= '0;
            addr_reg        <= '0;
            pixel_reg       <= '0;
            hcount_out_reg  <= '0;
            vcount_out_reg  <= '0;
            addr_out_reg    <= '0;
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            high_reg        <= high_next;
            hcount_reg      <= hcount_next;
            vcount_reg      <= vcount_next;
            addr_reg        <= addr_next;
            pixel_reg       <= pixel_next;
            hcount_out_reg  <= hcount_out_next;
            vcount_out_reg  <= vcount_out_next;
            addr_out_reg    <= addr_out_next;
            pixel_valid_reg <= pixel_valid_next;
            frame_done_reg  <= frame_done_next;
            frame_error_reg <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        high_next        = high_reg;
        hcount_next      = hcount_reg;
        vcount_next      = vcount_reg;
        addr_next        = addr_reg;
        pixel_next       = pixel_reg;
        hcount_out_next  = hcount_out_reg;
        vcount_out_next  = vcount_out_reg;
        addr_out_next    = addr_out_reg;
        pixel_valid_next = 1'b0;
        frame_done_next  = 1'b0;
        frame_error_next = 1'b0;
        last_pixel       = (hcount_reg == H_LAST) && (vcount_reg == V_LAST);

        if (bus.chip_sel_in) begin
            // A transfer that ends mid-frame is a short frame; any byte in this cycle is ignored
            state_next       = IDLE;
            frame_error_next = (state_reg == HI) || (state_reg == LO);
        end else begin
            unique case (state_reg)
                IDLE: begin
                    state_next  = HI;
                    hcount_next = '0;
                    vcount_next = '0;
                    addr_next   = '0;
                end
                HI: begin
                    if (bus.byte_valid_in) begin
                        high_next  = bus.byte_in;
                        state_next = LO;
                    end
                end
                LO: begin
                    if (bus.byte_valid_in) begin
                        pixel_next       = {high_reg, bus.byte_in};
                        hcount_out_next  = hcount_reg;
                        vcount_out_next  = vcount_reg;
                        addr_out_next    = addr_reg;
                        pixel_valid_next = 1'b1;
                        frame_done_next  = last_pixel;
                        state_next       = last_pixel ? FULL : HI;
                        // Address advances incrementally so no multiplier is needed
                        addr_next        = addr_reg + AW'(1);
                        if (hcount_reg == H_LAST) begin
                            hcount_next = '0;
                            vcount_next = vcount_reg + VW'(1);
                        end else begin
                            hcount_next = hcount_reg + HW'(1);
                        end
                    end
                end
                FULL: begin
                    frame_error_next = bus.byte_valid_in;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.pixel_out       = pixel_reg;
    assign bus.pixel_valid_out = pixel_valid_reg;
    assign bus.hcount_out      = hcount_out_reg;
    assign bus.vcount_out      = vcount_out_reg;
    assign bus.addr_out        = addr_out_reg;
    assign bus.frame_done_out  = frame_done_reg;
    assign bus.frame_error_out = frame_error_reg;
endmodule
